// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point FFT sequencer peripheral.
//   - register word offsets relative to BASE_ADDR
//   - CTRL / STATUS bit positions
//   - sequencer state encoding
//   - Q1.14 unity constant used by the twiddle ROM
package fft16_pkg;

  localparam logic [13:0] REG_CTRL    = 14'd0;
  localparam logic [13:0] REG_STATUS  = 14'd1;
  localparam logic [13:0] REG_IDX     = 14'd2;
  localparam logic [13:0] REG_DATA_RE = 14'd3;
  localparam logic [13:0] REG_DATA_IM = 14'd4;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_IE       = 2;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  localparam logic signed [15:0] Q14_ONE = 16'sd16384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGE0 = 2'd1,
    STAGE1 = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle factor ROM: W16^e = cos(2*pi*e/16) - j*sin(2*pi*e/16) in Q1.14.
// Ports:
//   exponent  in  4   twiddle exponent (0..9 used; others return 1+0j)
//   cos_q14   out 16  real part, signed Q1.14
//   nsin_q14  out 16  imaginary part (-sin), signed Q1.14
module fft_twiddle_rom
  import fft16_pkg::*;
(
  input  logic        [3:0]  exponent,
  output logic signed [15:0] cos_q14,
  output logic signed [15:0] nsin_q14
);

  always_comb begin
    cos_q14  = Q14_ONE;
    nsin_q14 = 16'sd0;
    unique case (exponent)
      4'd0: begin cos_q14 =  Q14_ONE;   nsin_q14 =  16'sd0;     end
      4'd1: begin cos_q14 =  16'sd15137; nsin_q14 = -16'sd6270;  end
      4'd2: begin cos_q14 =  16'sd11585; nsin_q14 = -16'sd11585; end
      4'd3: begin cos_q14 =  16'sd6270;  nsin_q14 = -16'sd15137; end
      4'd4: begin cos_q14 =  16'sd0;     nsin_q14 = -Q14_ONE;    end
      4'd5: begin cos_q14 = -16'sd6270;  nsin_q14 = -16'sd15137; end
      4'd6: begin cos_q14 = -16'sd11585; nsin_q14 = -16'sd11585; end
      4'd7: begin cos_q14 = -16'sd15137; nsin_q14 = -16'sd6270;  end
      4'd8: begin cos_q14 = -Q14_ONE;    nsin_q14 =  16'sd0;     end
      4'd9: begin cos_q14 = -16'sd15137; nsin_q14 =  16'sd6270;  end
      default: begin cos_q14 = Q14_ONE;  nsin_q14 =  16'sd0;     end
    endcase
  end

endmodule

// File: rtl/fft16_sequencer.sv
// 16-point radix-4 FFT sequencer on a 16-bit peripheral bus.
// Holds a 16-word complex buffer, feeds an external radix-4 butterfly one
// butterfly per cycle (2 stages x 4), applies stage-0 twiddles and writes
// results back in place. Results read back in natural order after done.
// Optional feature: define FFT_SEQ_IRQ_EN for a registered completion irq
// (irq = done & CTRL.ie); otherwise irq is 0 and CTRL.ie is not stored.
// Ports:
//   mclk, puc_rst           clock, synchronous active-high reset
//   per_addr/din/en/we      peripheral bus request (word address, data, enable, strobes)
//   per_dout                read data (0 when not reading)
//   bf_in_re/im             butterfly operands A..D, A at [15:0]; 0 when idle
//   bf_out_re/im            butterfly results Y0..Y3, same packing
//   irq                     completion interrupt
module fft16_sequencer
  import fft16_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR = 14'h0088
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [63:0] bf_in_re,
  output logic [63:0] bf_in_im,
  input  logic [63:0] bf_out_re,
  input  logic [63:0] bf_out_im,
  output logic        irq
);

  seq_state_t state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       busy, finish;

  logic       done, view, ie;
  logic [3:0] idx, rd_idx;
  logic signed [15:0] buf_re [16];
  logic signed [15:0] buf_im [16];

  logic wr, rd;
  logic sel_ctrl, sel_status, sel_idx, sel_re, sel_im;
  logic start_req, start_go, clr_wr, buf_wr;

  logic        [3:0]  op_addr [4];
  logic        [3:0]  tw_exp  [4];
  logic signed [15:0] tw_re   [4];
  logic signed [15:0] tw_im   [4];
  logic signed [15:0] o_re    [4];
  logic signed [15:0] o_im    [4];
  logic signed [15:0] res_re  [4];
  logic signed [15:0] res_im  [4];

  // Bus decode
  assign wr         = per_en && (per_we == 2'b11);
  assign rd         = per_en && (per_we == 2'b00);
  assign sel_ctrl   = (per_addr == BASE_ADDR + REG_CTRL);
  assign sel_status = (per_addr == BASE_ADDR + REG_STATUS);
  assign sel_idx    = (per_addr == BASE_ADDR + REG_IDX);
  assign sel_re     = (per_addr == BASE_ADDR + REG_DATA_RE);
  assign sel_im     = (per_addr == BASE_ADDR + REG_DATA_IM);

  assign start_req = wr && sel_ctrl && per_din[CTRL_START];
  assign start_go  = start_req && (state == IDLE);
  assign clr_wr    = wr && sel_ctrl && per_din[CTRL_CLR_DONE];
  assign buf_wr    = !busy && wr && (sel_re || sel_im);

  // Sequencer FSM
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = (state != IDLE);
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          state_next = STAGE0;
          cnt_next   = '0;
        end
      end
      STAGE0: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) state_next = STAGE1;
      end
      STAGE1: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/result addresses coincide: stage 0 uses n+4m, stage 1 uses 4q+m,
  // so the butterfly writes straight back over its own operands.
  always_comb begin
    for (int unsigned m = 0; m < 4; m++) begin
      op_addr[m] = (state == STAGE1) ? {cnt, 2'(m)} : {2'(m), cnt};
      tw_exp[m]  = (state == STAGE0) ? 4'(m) * {2'b00, cnt} : 4'd0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_tw
    fft_twiddle_rom u_rom (
      .exponent (tw_exp[g]),
      .cos_q14  (tw_re[g]),
      .nsin_q14 (tw_im[g])
    );
  end

  // Stage 1 selects exponent 0 (exact unity), so one multiplier path serves both stages.
  always_comb begin
    for (int unsigned q = 0; q < 4; q++) begin
      o_re[q]   = bf_out_re[16*q +: 16];
      o_im[q]   = bf_out_im[16*q +: 16];
      res_re[q] = 16'((32'(o_re[q]) * 32'(tw_re[q]) - 32'(o_im[q]) * 32'(tw_im[q])) >>> 14);
      res_im[q] = 16'((32'(o_re[q]) * 32'(tw_im[q]) + 32'(o_im[q]) * 32'(tw_re[q])) >>> 14);
    end
  end

  always_comb begin
    bf_in_re = '0;
    bf_in_im = '0;
    if (busy) begin
      for (int unsigned m = 0; m < 4; m++) begin
        bf_in_re[16*m +: 16] = buf_re[op_addr[m]];
        bf_in_im[16*m +: 16] = buf_im[op_addr[m]];
      end
    end
  end

  // Buffer, index and status registers
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      done <= 1'b0;
      view <= 1'b0;
      idx  <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
      end
    end else begin
      if (busy) begin
        for (int unsigned m = 0; m < 4; m++) begin
          buf_re[op_addr[m]] <= res_re[m];
          buf_im[op_addr[m]] <= res_im[m];
        end
      end else begin
        if (wr && sel_re) buf_re[idx] <= per_din;
        if (wr && sel_im) buf_im[idx] <= per_din;
        if (wr && sel_idx)
          idx <= per_din[3:0];
        else if ((wr || rd) && sel_im)
          idx <= idx + 4'd1;
      end

      if (finish)
        done <= 1'b1;
      else if (start_go || clr_wr || buf_wr)
        done <= 1'b0;

      // Natural-order read mapping persists after done until data is rewritten.
      if (finish)
        view <= 1'b1;
      else if (start_go || buf_wr)
        view <= 1'b0;
    end
  end

`ifdef FFT_SEQ_IRQ_EN
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr && sel_ctrl) ie <= per_din[CTRL_IE];
      irq <= done && ie;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // Read mux: X[k] lives at buf[4*(k%4) + k/4] after a run
  assign rd_idx = view ? {idx[1:0], idx[3:2]} : idx;

  always_comb begin
    per_dout = '0;
    if (rd) begin
      if (sel_ctrl) begin
        per_dout[CTRL_IE] = ie;
      end else if (sel_status) begin
        per_dout[STAT_BUSY] = busy;
        per_dout[STAT_DONE] = done;
      end else if (sel_idx) begin
        per_dout[3:0] = idx;
      end else if (sel_re) begin
        if (!busy) per_dout = buf_re[rd_idx];
      end else if (sel_im) begin
        if (!busy) per_dout = buf_im[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_fft16_sequencer.sv
// Directed self-checking bench for fft16_sequencer with a behavioural
// radix-4 butterfly driving bf_out_* from bf_in_*.
module tb_fft16_sequencer;
  import fft16_pkg::*;

  localparam logic [13:0] BASE = 14'h0088;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [63:0] bf_in_re, bf_in_im, bf_out_re, bf_out_im;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] in_re [16];
  logic [15:0] in_im [16];
  logic [15:0] exp_re [16];
  logic [15:0] exp_im [16];

  int tw_re_tab [16] = '{1000, 923, 707, 382, 0, -383, -708, -924,
                         -1000, -923, -707, -382, 0, 383, 708, 924};
  int tw_im_tab [16] = '{0, -383, -708, -924, -1000, -923, -707, -382,
                         0, 383, 708, 924, 1000, 923, 707, 382};

  always #5 mclk = ~mclk;

  fft16_sequencer #(.BASE_ADDR(BASE)) dut (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .bf_in_re  (bf_in_re),
    .bf_in_im  (bf_in_im),
    .bf_out_re (bf_out_re),
    .bf_out_im (bf_out_im),
    .irq       (irq)
  );

  // Radix-4 DFT: Y[p] = sum_m x[m] * (-j)^(p*m)
  logic signed [15:0] ar, ai, br, bi, cr, ci, dr, di;
  logic signed [15:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;
  always_comb begin
    ar = bf_in_re[15:0];  ai = bf_in_im[15:0];
    br = bf_in_re[31:16]; bi = bf_in_im[31:16];
    cr = bf_in_re[47:32]; ci = bf_in_im[47:32];
    dr = bf_in_re[63:48]; di = bf_in_im[63:48];
    y0r = ar + br + cr + dr;  y0i = ai + bi + ci + di;
    y1r = ar + bi - cr - di;  y1i = ai - br - ci + dr;
    y2r = ar - br + cr - dr;  y2i = ai - bi + ci - di;
    y3r = ar - bi - cr + di;  y3i = ai + br - ci - dr;
    bf_out_re = {y3r, y2r, y1r, y0r};
    bf_out_im = {y3i, y2i, y1i, y0i};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [13:0] off, input logic [1:0] we, input logic [15:0] din);
    per_en = 1'b1; per_we = we; per_addr = BASE + off; per_din = din;
    @(negedge mclk);
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic bus_rd(input logic [13:0] off, output logic [15:0] data);
    per_en = 1'b1; per_we = 2'b00; per_addr = BASE + off;
    #1 data = per_dout;
    @(negedge mclk);
    per_en = 1'b0;
  endtask

  task automatic clear_in;
    for (int i = 0; i < 16; i++) begin
      in_re[i] = '0; in_im[i] = '0; exp_re[i] = '0; exp_im[i] = '0;
    end
  endtask

  task automatic load_in;
    bus_wr(REG_IDX, 2'b11, 16'd0);
    for (int k = 0; k < 16; k++) begin
      bus_wr(REG_DATA_RE, 2'b11, in_re[k]);
      bus_wr(REG_DATA_IM, 2'b11, in_im[k]);
    end
  endtask

  task automatic wait_done(input string tag);
    logic [15:0] s;
    int n;
    s = 16'h0001;
    n = 0;
    while (s[0] && n < 30) begin
      bus_rd(REG_STATUS, s);
      n++;
    end
    check(tag, 64'(s[0]), 64'd0);
  endtask

  task automatic check_results(input string tag);
    logic [15:0] d;
    bus_wr(REG_IDX, 2'b11, 16'd0);
    for (int k = 0; k < 16; k++) begin
      bus_rd(REG_DATA_RE, d);
      check($sformatf("%s_X%0d_re", tag, k), 64'(d), 64'(exp_re[k]));
      bus_rd(REG_DATA_IM, d);
      check($sformatf("%s_X%0d_im", tag, k), 64'(d), 64'(exp_im[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic        irq_before;
    logic        irq_exp;
    logic [15:0] ctrl_exp;
`ifdef FFT_SEQ_IRQ_EN
    irq_exp  = 1'b1;
    ctrl_exp = 16'h0004;
`else
    irq_exp  = 1'b0;
    ctrl_exp = 16'h0000;
`endif

    puc_rst = 1'b1; per_en = 1'b0; per_we = 2'b00; per_addr = '0; per_din = '0;
    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;

    // Reset state
    check("rst_dout_idle", 64'(per_dout), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_bf_in_re", bf_in_re, 64'd0);
    check("rst_bf_in_im", bf_in_im, 64'd0);
    bus_rd(REG_STATUS, d);  check("rst_status", 64'(d), 64'd0);
    bus_rd(REG_CTRL, d);    check("rst_ctrl", 64'(d), 64'd0);
    bus_rd(REG_IDX, d);     check("rst_idx", 64'(d), 64'd0);
    bus_rd(REG_DATA_RE, d); check("rst_data_re", 64'(d), 64'd0);

    // Impulse with cycle-exact busy/done/irq timing
    clear_in();
    in_re[0] = 16'd1000;
    for (int k = 0; k < 16; k++) exp_re[k] = 16'd1000;
    load_in();
    bus_wr(REG_CTRL, 2'b11, 16'h0005);
    for (int i = 0; i < 8; i++) begin
      bus_rd(REG_STATUS, d);
      check($sformatf("busy_cycle%0d", i), 64'(d), 64'h0001);
    end
    irq_before = irq;
    bus_rd(REG_STATUS, d);
    check("done_after_8", 64'(d), 64'h0002);
    check("irq_with_done", 64'(irq_before), 64'd0);
    check("irq_next_edge", 64'(irq), 64'(irq_exp));
    bus_rd(REG_CTRL, d);
    check("ctrl_after_run", 64'(d), 64'(ctrl_exp));
    check_results("impulse");
    bus_wr(REG_CTRL, 2'b11, 16'h0002);
    bus_rd(REG_STATUS, d);
    check("clr_done", 64'(d), 64'd0);

    // DC input, with bus accesses while busy
    clear_in();
    for (int k = 0; k < 16; k++) in_re[k] = 16'd100;
    exp_re[0] = 16'd1600;
    load_in();
    bus_wr(REG_CTRL, 2'b11, 16'h0001);
    bus_rd(REG_DATA_RE, d);
    check("busy_data_read", 64'(d), 64'd0);
    bus_wr(REG_DATA_RE, 2'b11, 16'h1234);
    bus_wr(REG_IDX, 2'b11, 16'd5);
    wait_done("dc_wait");
    bus_rd(REG_IDX, d);
    check("busy_idx_write", 64'(d), 64'd0);
    check_results("dc");

    // Shifted impulse x[4]
    clear_in();
    in_re[4] = 16'd1000;
    for (int k = 0; k < 16; k += 4) begin
      exp_re[k]   = 16'd1000;
      exp_im[k+1] = 16'(-1000);
      exp_re[k+2] = 16'(-1000);
      exp_im[k+3] = 16'd1000;
    end
    load_in();
    bus_wr(REG_CTRL, 2'b11, 16'h0001);
    wait_done("shift_wait");
    check_results("shift");

    // x[1]: X[k] = 1000 * W16^k with Q1.14 truncation
    clear_in();
    in_re[1] = 16'd1000;
    for (int k = 0; k < 16; k++) begin
      exp_re[k] = 16'(tw_re_tab[k]);
      exp_im[k] = 16'(tw_im_tab[k]);
    end
    load_in();
    bus_wr(REG_CTRL, 2'b11, 16'h0001);
    wait_done("twid_wait");
    check_results("twid");

    // Start while done=1: done clears and run begins
    bus_wr(REG_CTRL, 2'b11, 16'h0001);
    bus_rd(REG_STATUS, d);
    check("start_with_done", 64'(d), 64'h0001);
    wait_done("restart_wait");

    // Partial write strobes are ignored
    bus_wr(REG_CTRL, 2'b01, 16'h0001);
    bus_rd(REG_STATUS, d);
    check("we01_no_start", 64'(d), 64'h0002);
    bus_wr(REG_CTRL, 2'b10, 16'h0002);
    bus_rd(REG_STATUS, d);
    check("we10_no_clear", 64'(d), 64'h0002);

    // 17 DATA_IM reads wrap IDX to 1
    bus_wr(REG_IDX, 2'b11, 16'd0);
    for (int i = 0; i < 17; i++) bus_rd(REG_DATA_IM, d);
    bus_rd(REG_IDX, d);
    check("idx_wrap", 64'(d), 64'd1);

    // Reset at STAGE1 cnt=1
    clear_in();
    in_re[0] = 16'd1000;
    load_in();
    bus_wr(REG_CTRL, 2'b11, 16'h0001);
    repeat (5) @(negedge mclk);
    puc_rst = 1'b1;
    @(negedge mclk);
    puc_rst = 1'b0;
    check("midrst_bf_in", bf_in_re, 64'd0);
    bus_rd(REG_STATUS, d);
    check("midrst_status", 64'(d), 64'd0);
    bus_rd(REG_IDX, d);
    check("midrst_idx", 64'(d), 64'd0);
    for (int k = 0; k < 16; k++) begin
      bus_rd(REG_DATA_RE, d);
      check($sformatf("midrst_re%0d", k), 64'(d), 64'd0);
      bus_rd(REG_DATA_IM, d);
      check($sformatf("midrst_im%0d", k), 64'(d), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft16_sequencer.md
FFT16_SEQUENCER -- requirements
Module: fft16_sequencer

Interface
REQ-001 Parameter: BASE_ADDR, default 14'h0088, word address of the first peripheral register.
REQ-002 mclk  in  1  system clock; the only clock.
REQ-003 puc_rst  in  1  reset, synchronous, active-high.
REQ-004 per_addr  in  14  peripheral word address.
REQ-005 per_din  in  16  write data.
REQ-006 per_en  in  1  bus cycle enable.
REQ-007 per_we  in  2  write strobes.
REQ-008 per_dout  out  16  read data.
REQ-009 bf_in_re / bf_in_im  out  64 each  radix-4 butterfly operands A,B,C,D, packed with A at [15:0].
REQ-010 bf_out_re / bf_out_im  in  64 each  combinational butterfly results, same packing.
REQ-011 irq  out  1  completion interrupt.

Function
REQ-012 Registers: CTRL=BASE+0, STATUS=BASE+1, IDX=BASE+2, DATA_RE=BASE+3, DATA_IM=BASE+4.
REQ-013 Write: per_en && per_we==2'b11; other non-zero per_we values are ignored.
REQ-014 Read: per_en && per_we==0 drives the addressed register; otherwise per_dout=0.
REQ-015 Buffer: 16 complex words of signed 16-bit each; IDX[3:0] selects the word.
REQ-016 An access to DATA_IM (read or write) increments IDX; IDX wraps 15->0.
REQ-017 CTRL bits: bit0 start (self-clearing), bit1 clear done, bit2 irq enable.
REQ-018 STATUS bits: bit0 busy, bit1 done.
REQ-019 FSM states: IDLE -> STAGE0 (cnt 0..3) -> STAGE1 (cnt 0..3) -> IDLE, with done set on exit.
REQ-020 A start write in IDLE enters STAGE0 on the next edge; start is ignored while busy.
REQ-021 Start and done=1 together: done clears and the run starts.
REQ-022 Run length: exactly 8 busy cycles, one butterfly per cycle; results are written to the buffer on the same edge.
REQ-023 STAGE0, butterfly n: operands buf[n], buf[n+4], buf[n+8], buf[n+12].
REQ-024 STAGE0 results: output q is multiplied by W16^(q*n) and written to buf[n+4q].
REQ-025 STAGE1, butterfly q: operands buf[4q..4q+3].
REQ-026 STAGE1 results: output p is written to buf[4q+p] with no twiddle.
REQ-027 Twiddles are Q1.14; complex product = (a*w) >>> 14, truncated to 16 bits, with no saturation.
REQ-028 Reads after done map IDX k to buf[4*(k%4) + k/4] (natural-order X[k]).
REQ-029 Reads before completion, and after a new write, map IDX k to buf[k] directly.
REQ-030 Any buffer write clears done.
REQ-031 While busy: DATA and IDX writes are ignored, and DATA reads return 0.
REQ-032 bf_in_* is 0 when IDLE.

Reset
REQ-033 puc_rst, sampled at mclk, forces IDLE, including mid-run; partial results are discarded.
REQ-034 Reset values: busy=0, done=0, IDX=0, CTRL=0, all buffer words 0, per_dout=0, irq=0, bf_in_*=0.

Configuration
REQ-035 With FFT_SEQ_IRQ_EN defined: irq = done && CTRL.bit2, as a registered level output.
REQ-036 Without FFT_SEQ_IRQ_EN: irq is tied 0, and CTRL.bit2 is not stored and reads 0.

Structure
REQ-037 Package fft16_pkg holds the register offsets, the CTRL/STATUS bit indices, the FSM state enum and the Q1.14 constant 16384.
REQ-038 Sub-module fft_twiddle_rom maps a 4-bit exponent (0..9 used) combinationally to {cos, -sin} in Q1.14.
REQ-039 The butterfly arithmetic is external and is not instantiated here.

Verification
REQ-040 Impulse: x[0]=1000+0j, others 0, start -> X[k]=1000+0j for all 16 k.
REQ-041 DC: all x=100+0j -> X[0]=1600+0j, X[1..15]=0.
REQ-042 Shift: x[4]=1000, others 0 -> X[k] cycles through 1000, -1000j, -1000, +1000j for k mod 4 = 0..3.
REQ-043 Timing: start written on edge E0 -> busy=1 from E0 through E8, then busy=0, done=1; with IE=1 and the macro defined, irq=1 one edge later.
REQ-044 puc_rst asserted at STAGE1 cnt=1 -> next cycle busy=0, done=0, all DATA reads return 0.
REQ-045 Bus: a DATA write while busy has no effect; 17 consecutive DATA_IM reads wrap IDX to 1; per_we=2'b01 to CTRL does not start a run.
